if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage; the producer side that drives the IF/ID pipeline register.
- Holds the PC and issues instruction-memory reads over a valid/ready handshake.
- Delivers {PC+4, instruction} pairs downstream, holding them under stall.
- On a taken branch/jump, redirects the PC and generates the one-cycle IFID_flush pulse consumed by IF/ID.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_INC, 4, byte increment per sequential fetch.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst  in  1  asynchronous active-high reset.
- Stall  in  1  hazard unit: downstream will not accept; hold outputs and PC.
- Branch_taken  in  1  one-cycle redirect request from ID/EX.
- Branch_target  in  32  redirect address; bits [1:0] forced to 0.
- imem_req  out  1  read request valid.
- imem_addr  out  32  read address (current PC).
- imem_ready  in  1  memory accepts; imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- PCAdder_out  out  32  PC+4 of delivered instruction, to IF/ID PCAdder_in.
- Instruction_out  out  32  delivered instruction, to IF/ID Instruction_in.
- Valid_out  out  1  PCAdder_out/Instruction_out hold a real instruction.
- IFID_flush  out  1  squash the IF/ID contents this cycle.

Behaviour:
- Reset is asynchronous and active-high; single clock Clk.
- Reset values: PC=RESET_PC; state=BOOT; PCAdder_out=0; Instruction_out=0 (NOP); Valid_out=0; IFID_flush=0; imem_req=0; skid buffer empty.
- Transfer occurs when imem_req && imem_ready in the same cycle. There are no outstanding requests; deasserting imem_req cancels.
- imem_addr = PC whenever imem_req=1.
- State BOOT: imem_req=0 for one cycle after Rst deasserts, then -> FETCH.
- State FETCH: imem_req=1.
  - On transfer with Stall=0: register outputs next edge (Instruction_out=imem_rdata, PCAdder_out=PC+PC_INC, Valid_out=1) and set PC<=PC+PC_INC.
  - On transfer with Stall=1: capture the word into the skid buffer -> HOLD; PC unchanged.
  - No transfer: Valid_out<=0 and Instruction_out<=0 unless Stall=1, in which case outputs hold.
- State HOLD: imem_req=0; outputs unchanged. When Stall=0: load outputs from the skid buffer, PC<=PC+PC_INC -> FETCH.
- Latency: instruction appears on the outputs one cycle after its memory transfer. Throughput is 1 per cycle when imem_ready=1 and Stall=0.
- Redirect (Branch_taken=1) has priority over stall, transfer and HOLD:
  - PC<=Branch_target&~3.
  - Skid buffer cleared; state -> FETCH.
  - Valid_out<=0, Instruction_out<=0.
  - IFID_flush=1 for exactly that cycle (combinational from Branch_taken, registered variant not permitted).
  - Any same-cycle memory transfer is discarded.
- Branch_taken on consecutive cycles: the last target wins; IFID_flush stays high each cycle.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0, no error flag.
- Rst asserted mid-operation: immediate return to reset values, including a pending redirect.

Optional Feature:
- IF_DELAY_SLOT_EN defined: MIPS branch delay slot.
  - Branch_taken stores the target in a pending-redirect register; IFID_flush stays 0.
  - The next sequential instruction (the delay slot) is fetched and delivered normally.
  - On that slot's transfer, PC<=pending target and pending is cleared.
  - If the delay-slot fetch stalls or waits, pending holds.
  - A second Branch_taken while pending overwrites the target.
- Undefined: redirect is immediate with flush, as above.

Decomposition:
- Package if_pkg:
  - state enum {BOOT, FETCH, HOLD};
  - NOP_INSTR=32'h0;
  - PC_ALIGN_MASK=32'hFFFF_FFFC;
  - 32-bit word typedef.
- One sub-module: if_skid_buf, a 1-entry {pc_plus4, instr} buffer with load/clear/full.

Test Plan:
- Reset with RESET_PC=0, imem_ready=1, rdata=32'h2008_0005 at addr 0 -> first transfer at cycle 2 after release; next cycle Valid_out=1, Instruction_out=32'h2008_0005, PCAdder_out=4; imem_addr steps 0,4,8,...
- Stall=1 on the transfer of addr 8 for 3 cycles -> HOLD; imem_req=0; outputs remain the addr-4 instruction. Stall release -> addr-8 word delivered, PCAdder_out=12, next imem_addr=12.
- Branch_taken=1, target=32'h0000_0041 during FETCH with imem_ready=1 -> IFID_flush=1 that cycle; next Valid_out=0, Instruction_out=0; next imem_addr=32'h0000_0040.
- Branch_taken and Stall together in HOLD -> redirect wins: buffer cleared, flush=1, state FETCH at the target.
- PC=32'hFFFF_FFFC transfer -> PCAdder_out=0, next imem_addr=0.
- IF_DELAY_SLOT_EN: branch at PC=0x10, target 0x100 -> IFID_flush stays 0; instruction at 0x14 is delivered, then imem_addr=0x100. Rst pulsed mid-sequence -> all outputs 0, PC=RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Used by if_skid_buf and if_fetch_unit.
package if_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam word_t NOP_INSTR     = 32'h0000_0000;
  localparam word_t PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    word_t pc_plus4;
    word_t instr;
  } fetch_pair_t;

  function automatic word_t align_pc(input word_t a);
    return a & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc_plus4, instr} buffer that parks a word fetched
// while downstream is stalled.
module if_skid_buf
  import if_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        load,
  input  logic        clear,
  input  fetch_pair_t din,
  output fetch_pair_t dout,
  output logic        full
);

  fetch_pair_t data_q;
  logic        full_q;

  // clear wins over load so a redirect always empties the entry
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (clear) begin
      full_q <= 1'b0;
    end else if (load) begin
      data_q <= din;
      full_q <= 1'b1;
    end
  end

  assign dout = data_q;
  assign full = full_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, imem handshake, IF/ID output regs.
// IF_DELAY_SLOT_EN selects MIPS-style delayed branches.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter word_t       RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_INC   = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Branch_taken,
  input  logic [31:0] Branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCAdder_out,
  output logic [31:0] Instruction_out,
  output logic        Valid_out,
  output logic        IFID_flush
);

  state_t      state_q;
  state_t      state_nx;
  word_t       pc_q;
  word_t       pc_inc;
  word_t       pc_adv;
  word_t       pca_q;
  word_t       instr_q;
  logic        valid_q;
  logic        xfer;
  logic        redir;
  logic        adv_fetch;
  logic        cap_fetch;
  logic        adv_hold;
  logic        idle_fetch;
  logic        skid_full;
  fetch_pair_t skid_dout;

  assign xfer       = imem_req && imem_ready;
  assign pc_inc     = pc_q + word_t'(PC_INC);
  assign adv_fetch  = (state_q == FETCH) && xfer && !Stall;
  assign cap_fetch  = (state_q == FETCH) && xfer && Stall;
  assign adv_hold   = (state_q == HOLD) && skid_full && !Stall;
  assign idle_fetch = (state_q == FETCH) && !xfer && !Stall;

`ifdef IF_DELAY_SLOT_EN
  logic  pend_q;
  word_t pend_pc_q;
  logic  jump;

  assign redir  = 1'b0;
  assign jump   = pend_q && !Branch_taken;
  assign pc_adv = jump ? pend_pc_q : pc_inc;

  // pending target: set/overwritten by a branch, used by the slot
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pend_q    <= 1'b0;
      pend_pc_q <= RESET_PC;
    end else if (Branch_taken) begin
      pend_q    <= 1'b1;
      pend_pc_q <= align_pc(Branch_target);
    end else if (jump && (adv_fetch || adv_hold)) begin
      pend_q <= 1'b0;
    end
  end
`else
  assign redir  = Branch_taken;
  assign pc_adv = pc_inc;
`endif

  if_skid_buf u_skid (
    .Clk   (Clk),
    .Rst   (Rst),
    .load  (cap_fetch && !redir),
    .clear (redir || adv_hold),
    .din   ('{pc_plus4: pc_inc, instr: imem_rdata}),
    .dout  (skid_dout),
    .full  (skid_full)
  );

  // state register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= BOOT;
    else     state_q <= state_nx;
  end

  // next state: redirect overrides everything
  always_comb begin
    state_nx = state_q;
    if (redir) begin
      state_nx = FETCH;
    end else begin
      unique case (state_q)
        BOOT:    state_nx = FETCH;
        FETCH:   if (cap_fetch) state_nx = HOLD;
        HOLD:    if (adv_hold) state_nx = FETCH;
        default: state_nx = BOOT;
      endcase
    end
  end

  // outputs: request only in FETCH, flush straight from redirect
  always_comb begin
    imem_req   = (state_q == FETCH);
    imem_addr  = pc_q;
    IFID_flush = redir && !Rst;
  end

  // PC and IF/ID-facing output registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pc_q    <= RESET_PC;
      pca_q   <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (redir) begin
      pc_q    <= align_pc(Branch_target);
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (adv_fetch) begin
      pc_q    <= pc_adv;
      pca_q   <= pc_inc;
      instr_q <= imem_rdata;
      valid_q <= 1'b1;
    end else if (adv_hold) begin
      pc_q    <= pc_adv;
      pca_q   <= skid_dout.pc_plus4;
      instr_q <= skid_dout.instr;
      valid_q <= 1'b1;
    end else if (idle_fetch) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end
  end

  assign PCAdder_out     = pca_q;
  assign Instruction_out = instr_q;
  assign Valid_out       = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit.
// Memory returns 32'h2008_0005 + (addr << 8).
module tb_if_fetch_unit;

  logic        Clk;
  logic        Rst;
  logic        Stall;
  logic        Branch_taken;
  logic [31:0] Branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] PCAdder_out;
  logic [31:0] Instruction_out;
  logic        Valid_out;
  logic        IFID_flush;

  int n_vec = 0;
  int n_err = 0;

  if_fetch_unit dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .Stall           (Stall),
    .Branch_taken    (Branch_taken),
    .Branch_target   (Branch_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .PCAdder_out     (PCAdder_out),
    .Instruction_out (Instruction_out),
    .Valid_out       (Valid_out),
    .IFID_flush      (IFID_flush)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h2008_0005 + (a << 8);
  endfunction

  always_comb imem_rdata = mem(imem_addr);

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic v,
                      input logic [31:0] ins,
                      input logic [31:0] pca);
    check({tag, ".valid"}, {31'd0, Valid_out}, {31'd0, v});
    check({tag, ".instr"}, Instruction_out, ins);
    check({tag, ".pca"}, PCAdder_out, pca);
  endtask

  initial begin
    Rst = 1'b1;
    Stall = 1'b0;
    Branch_taken = 1'b0;
    Branch_target = '0;
    imem_ready = 1'b1;
    tick();
    tick();
    outs("rst", 1'b0, 32'h0, 32'h0);
    check("rst.req", {31'd0, imem_req}, 32'd0);
    check("rst.flush", {31'd0, IFID_flush}, 32'd0);
    Rst = 1'b0;
    #1;
    check("boot.req", {31'd0, imem_req}, 32'd0);
    tick();
    check("f0.req", {31'd0, imem_req}, 32'd1);
    check("f0.addr", imem_addr, 32'h0);
    tick();
    outs("d0", 1'b1, 32'h2008_0005, 32'h4);
    check("d0.addr", imem_addr, 32'h4);
    tick();
    outs("d4", 1'b1, mem(32'h4), 32'h8);
    check("d4.addr", imem_addr, 32'h8);
`ifdef IF_DELAY_SLOT_EN
    tick();
    check("ds8.addr", imem_addr, 32'hC);
    tick();
    check("dsC.addr", imem_addr, 32'h10);
    Branch_taken = 1'b1;
    Branch_target = 32'h0000_0100;
    #1;
    check("ds.flush", {31'd0, IFID_flush}, 32'd0);
    tick();
    Branch_taken = 1'b0;
    outs("ds10", 1'b1, mem(32'h10), 32'h14);
    check("ds10.addr", imem_addr, 32'h14);
    tick();
    outs("ds14", 1'b1, mem(32'h14), 32'h18);
    check("ds14.addr", imem_addr, 32'h100);
    tick();
    outs("ds100", 1'b1, mem(32'h100), 32'h104);
    Rst = 1'b1;
    #1;
    outs("dsrst", 1'b0, 32'h0, 32'h0);
    check("dsrst.addr", imem_addr, 32'h0);
    Rst = 1'b0;
`else
    Stall = 1'b1;
    tick();
    check("h1.req", {31'd0, imem_req}, 32'd0);
    outs("h1", 1'b1, mem(32'h4), 32'h8);
    tick();
    tick();
    outs("h3", 1'b1, mem(32'h4), 32'h8);
    Stall = 1'b0;
    tick();
    outs("rel8", 1'b1, mem(32'h8), 32'hC);
    check("rel8.addr", imem_addr, 32'hC);
    check("rel8.req", {31'd0, imem_req}, 32'd1);
    Branch_taken = 1'b1;
    Branch_target = 32'h0000_0041;
    #1;
    check("br.flush", {31'd0, IFID_flush}, 32'd1);
    tick();
    Branch_taken = 1'b0;
    #1;
    check("br.flush_lo", {31'd0, IFID_flush}, 32'd0);
    check("br.valid", {31'd0, Valid_out}, 32'd0);
    check("br.instr", Instruction_out, 32'h0);
    check("br.addr", imem_addr, 32'h40);
    tick();
    outs("d40", 1'b1, mem(32'h40), 32'h44);
    Stall = 1'b1;
    tick();
    check("h44.req", {31'd0, imem_req}, 32'd0);
    Branch_taken = 1'b1;
    Branch_target = 32'hFFFF_FFFE;
    #1;
    check("hbr.flush", {31'd0, IFID_flush}, 32'd1);
    tick();
    Branch_taken = 1'b0;
    Stall = 1'b0;
    #1;
    check("hbr.req", {31'd0, imem_req}, 32'd1);
    check("hbr.addr", imem_addr, 32'hFFFF_FFFC);
    check("hbr.valid", {31'd0, Valid_out}, 32'd0);
    tick();
    outs("wrap", 1'b1, mem(32'hFFFF_FFFC), 32'h0);
    check("wrap.addr", imem_addr, 32'h0);
    imem_ready = 1'b0;
    tick();
    outs("idle", 1'b0, 32'h0, 32'h0);
    check("idle.addr", imem_addr, 32'h0);
    imem_ready = 1'b1;
    tick();
    outs("d0b", 1'b1, mem(32'h0), 32'h4);
    imem_ready = 1'b0;
    Stall = 1'b1;
    tick();
    outs("stwait", 1'b1, mem(32'h0), 32'h4);
    check("stwait.addr", imem_addr, 32'h4);
    Branch_taken = 1'b1;
    Branch_target = 32'h0000_0080;
    Rst = 1'b1;
    #1;
    outs("mrst", 1'b0, 32'h0, 32'h0);
    check("mrst.addr", imem_addr, 32'h0);
    check("mrst.flush", {31'd0, IFID_flush}, 32'd0);
    tick();
    Branch_taken = 1'b0;
    Stall = 1'b0;
    imem_ready = 1'b1;
    Rst = 1'b0;
    tick();
    check("mrst.req", {31'd0, imem_req}, 32'd1);
    check("mrst.addr2", imem_addr, 32'h0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
